ibutterfly_4: RTL and testbench

//   Inverse 4-point butterfly for the inverse-transform (reconstruction) path.

---
 rtl/ibutterfly_4.sv | 168 ++++++++++++++++
 tb/tb_ibutterfly_4.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibutterfly_4.sv
// ibutterfly_4: inverse 4-point butterfly, 2-stage elastic pipeline.
// Rebuilds four OUT_W-bit samples from the forward butterfly sum/difference terms.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   i_valid/i_ready input handshake; i_0..i_3 are terms b0..b3 (IN_W, signed)
//   o_valid/o_ready output handshake; o_0..o_3 are samples x0..x3 (OUT_W, signed)
//   o_err           beat had an odd pair sum (qualified by o_valid)
//   o_sat           at least one sample was clamped (qualified by o_valid)
//   err_clr         clears err_cnt (wins over increment)
//   err_cnt         saturating count of delivered beats with o_err=1
module ibutterfly_4 #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 24,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic signed [IN_W-1:0]  i_0,
  input  logic signed [IN_W-1:0]  i_1,
  input  logic signed [IN_W-1:0]  i_2,
  input  logic signed [IN_W-1:0]  i_3,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [OUT_W-1:0] o_0,
  output logic signed [OUT_W-1:0] o_1,
  output logic signed [OUT_W-1:0] o_2,
  output logic signed [OUT_W-1:0] o_3,
  output logic                    o_err,
  output logic                    o_sat,
  input  logic                    err_clr,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int SW = IN_W + 1;

  // Sums carry one extra bit so b+b never wraps.
  logic          s1_v;
  logic          s1_err;
  logic [SW-1:0] sa;
  logic [SW-1:0] sb;
  logic [SW-1:0] sc;
  logic [SW-1:0] sd;

  logic [SW-1:0] b0;
  logic [SW-1:0] b1;
  logic [SW-1:0] b2;
  logic [SW-1:0] b3;

  logic [SW-1:0] n_sa;
  logic [SW-1:0] n_sb;
  logic [SW-1:0] n_sc;
  logic [SW-1:0] n_sd;

  logic             s2_adv;
  logic [OUT_W-1:0] n_0;
  logic [OUT_W-1:0] n_1;
  logic [OUT_W-1:0] n_2;
  logic [OUT_W-1:0] n_3;
  logic             n_sat;

  // Halve with floor rounding.
  function automatic logic [SW-1:0] half(input logic [SW-1:0] v);
    half = SW'($signed(v) >>> 1);
  endfunction

  // The halved value fits OUT_W iff its bits above the OUT_W sign bit
  // are all copies of that sign bit.
  function automatic logic ovf(input logic [SW-1:0] v);
    logic [SW-1:0]     h;
    logic [SW-OUT_W:0] top;
    h   = half(v);
    top = h[SW-1:OUT_W-1];
    ovf = !((&top) || !(|top));
  endfunction

  function automatic logic [OUT_W-1:0] clip(input logic [SW-1:0] v);
    logic [SW-1:0] h;
    h = half(v);
    if (!ovf(v))
      clip = h[OUT_W-1:0];
    else if (h[SW-1])
      clip = {1'b1, {(OUT_W-1){1'b0}}};
    else
      clip = {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  // Output register frees up when empty or being drained this cycle.
  assign s2_adv  = !o_valid || o_ready;
  assign i_ready = !s1_v || s2_adv;

  assign b0 = {i_0[IN_W-1], i_0};
  assign b1 = {i_1[IN_W-1], i_1};
  assign b2 = {i_2[IN_W-1], i_2};
  assign b3 = {i_3[IN_W-1], i_3};

  always_comb begin
    n_sa = b0 + b3;
    n_sb = b1 + b2;
    n_sc = b1 - b2;
    n_sd = b0 - b3;
  end

  always_comb begin
    n_0   = clip(sa);
    n_1   = clip(sb);
    n_2   = clip(sc);
    n_3   = clip(sd);
    n_sat = ovf(sa) | ovf(sb) | ovf(sc) | ovf(sd);
  end

  // Stage 1: when i_ready, s1 is empty or moving on, so it may take the
  // new beat (or a bubble when i_valid is low).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_err <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      sc     <= '0;
      sd     <= '0;
    end else if (i_ready) begin
      s1_v <= i_valid;
      if (i_valid) begin
        sa     <= n_sa;
        sb     <= n_sb;
        sc     <= n_sc;
        sd     <= n_sd;
        s1_err <= n_sa[0] | n_sb[0];
      end
    end
  end

  // Stage 2: output register, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_0     <= '0;
      o_1     <= '0;
      o_2     <= '0;
      o_3     <= '0;
      o_err   <= 1'b0;
      o_sat   <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_v;
      if (s1_v) begin
        o_0   <= n_0;
        o_1   <= n_1;
        o_2   <= n_2;
        o_3   <= n_3;
        o_err <= s1_err;
        o_sat <= n_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (o_valid && o_ready && o_err && (err_cnt != '1))
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ibutterfly_4.sv
// tb_ibutterfly_4: directed, table-driven bench for ibutterfly_4.
// A second instance with a 2-bit error counter shares all inputs.
module tb_ibutterfly_4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic i_valid = 1'b0;
  logic o_ready = 1'b1;
  logic err_clr = 1'b0;
  logic signed [24:0] i_0 = '0;
  logic signed [24:0] i_1 = '0;
  logic signed [24:0] i_2 = '0;
  logic signed [24:0] i_3 = '0;

  logic i_ready, o_valid, o_err, o_sat;
  logic signed [23:0] o_0, o_1, o_2, o_3;
  logic [15:0] err_cnt;

  logic c_i_ready, c_o_valid, c_err, c_sat;
  logic signed [23:0] c_0, c_1, c_2, c_3;
  logic [1:0] c_err_cnt;

  ibutterfly_4 u_dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_0(i_0), .i_1(i_1), .i_2(i_2), .i_3(i_3),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_0(o_0), .o_1(o_1), .o_2(o_2), .o_3(o_3),
    .o_err(o_err), .o_sat(o_sat),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  ibutterfly_4 #(.CNT_W(2)) u_small (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(c_i_ready),
    .i_0(i_0), .i_1(i_1), .i_2(i_2), .i_3(i_3),
    .o_valid(c_o_valid), .o_ready(o_ready),
    .o_0(c_0), .o_1(c_1), .o_2(c_2), .o_3(c_3),
    .o_err(c_err), .o_sat(c_sat),
    .err_clr(err_clr), .err_cnt(c_err_cnt)
  );

  typedef struct {
    int b0, b1, b2, b3;
    int x0, x1, x2, x3;
    int err, sat;
  } vec_t;

  vec_t tv[8];
  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  int c_exp = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_0 = 25'(v.b0);
    i_1 = 25'(v.b1);
    i_2 = 25'(v.b2);
    i_3 = 25'(v.b3);
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, " o_valid"}, int'(o_valid), 1);
    chk({nm, " o_0"}, int'(o_0), v.x0);
    chk({nm, " o_1"}, int'(o_1), v.x1);
    chk({nm, " o_2"}, int'(o_2), v.x2);
    chk({nm, " o_3"}, int'(o_3), v.x3);
    chk({nm, " o_err"}, int'(o_err), v.err);
    chk({nm, " o_sat"}, int'(o_sat), v.sat);
  endtask

  task automatic note_xfer(input vec_t v);
    if (v.err != 0) begin
      err_exp = err_exp + 1;
      c_exp = (c_exp < 3) ? c_exp + 1 : 3;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Streams n beats (fixed>=0: always tv[fixed]) with an optional o_ready
  // stall window; checks order, values, i_ready and counters every cycle.
  task automatic run_stream(input string nm, input int n, input int fixed,
                            input int stall_at, input int stall_len,
                            input int max_cyc);
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    int occ;
    vec_t e;
    while (recv < n && cyc < max_cyc) begin
      o_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      i_valid = (sent < n);
      if (sent < n) drive(tv[fixed >= 0 ? fixed : sent % 8]);
      #1;
      occ = sent - recv;
      chk({nm, " i_ready"}, int'(i_ready), (occ < 2 || o_ready) ? 1 : 0);
      chk({nm, " err_cnt"}, int'(err_cnt), err_exp);
      chk({nm, " small err_cnt"}, int'(c_err_cnt), c_exp);
      if (o_valid) begin
        e = tv[fixed >= 0 ? fixed : recv % 8];
        chk_out($sformatf("%s beat%0d", nm, recv), e);
        if (o_ready) begin
          note_xfer(e);
          recv++;
        end
      end
      if (i_valid && i_ready) sent++;
      step();
      cyc++;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    if (recv < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d beats expected %0d", nm, recv, n);
    end else if (stall_len == 0) begin
      chk({nm, " cycles"}, cyc, n + 2);
    end
  endtask

  initial begin
    tv[0] = '{100, -43, -57, 100, 100, -50, 7, 0, 0, 0};
    tv[1] = '{3, 0, 0, 0, 1, 0, 0, 1, 1, 0};
    tv[2] = '{16777215, 0, 0, 16777215, 8388607, 0, 0, 0, 0, 1};
    tv[3] = '{-16777216, 0, 0, -16777216, -8388608, 0, 0, 0, 0, 1};
    tv[4] = '{10, 7, -3, -6, 2, 2, 5, 8, 0, 0};
    tv[5] = '{-5, 2, 1, 0, -3, 1, 0, -3, 1, 0};
    tv[6] = '{0, 16777215, -16777216, 0, 0, -1, 8388607, 0, 1, 1};
    tv[7] = '{-100, 50, -50, -40, -70, 0, 50, -30, 0, 0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset o_valid", int'(o_valid), 0);
    chk("reset o_0", int'(o_0), 0);
    chk("reset o_3", int'(o_3), 0);
    chk("reset o_err", int'(o_err), 0);
    chk("reset o_sat", int'(o_sat), 0);
    chk("reset err_cnt", int'(err_cnt), 0);
    chk("reset i_ready", int'(i_ready), 1);

    for (int i = 0; i < 8; i++) begin
      drive(tv[i]);
      i_valid = 1'b1;
      o_ready = 1'b1;
      step();
      i_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d latency1 o_valid", i), int'(o_valid), 0);
      step();
      #1;
      chk_out($sformatf("vec%0d", i), tv[i]);
      note_xfer(tv[i]);
    end
    step();
    #1;
    chk("table drained o_valid", int'(o_valid), 0);
    chk("table err_cnt", int'(err_cnt), err_exp);
    chk("table small err_cnt", int'(c_err_cnt), c_exp);

    run_stream("flow", 16, -1, 0, 0, 100);
    run_stream("bp", 6, -1, 3, 5, 100);
    #1;
    chk("bp err_cnt", int'(err_cnt), err_exp);

    o_ready = 1'b0;
    drive(tv[1]);
    i_valid = 1'b1;
    step();
    drive(tv[5]);
    step();
    i_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    err_exp = 0;
    c_exp = 0;
    #1;
    chk("midrst o_valid", int'(o_valid), 0);
    chk("midrst o_0", int'(o_0), 0);
    chk("midrst o_1", int'(o_1), 0);
    chk("midrst o_err", int'(o_err), 0);
    chk("midrst o_sat", int'(o_sat), 0);
    chk("midrst err_cnt", int'(err_cnt), 0);
    chk("midrst small err_cnt", int'(c_err_cnt), 0);
    chk("midrst i_ready", int'(i_ready), 1);
    o_ready = 1'b1;
    drive(tv[0]);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    #1;
    chk("postrst latency1 o_valid", int'(o_valid), 0);
    step();
    #1;
    chk_out("postrst", tv[0]);
    note_xfer(tv[0]);
    step();

    run_stream("odd", 5, 1, 0, 0, 50);
    #1;
    chk("odd err_cnt", int'(err_cnt), 5);
    chk("odd small err_cnt sat", int'(c_err_cnt), 3);

    drive(tv[1]);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    #1;
    chk("clr o_valid", int'(o_valid), 1);
    chk("clr o_err", int'(o_err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    #1;
    chk("clr err_cnt", int'(err_cnt), 0);
    chk("clr small err_cnt", int'(c_err_cnt), 0);
    chk("clr drained o_valid", int'(o_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
